// File: rtl/gol_gen_sequencer.sv
// -----------------------------------------------------------------------------
// gol_gen_sequencer
//
// Purpose:
//   Sequences one Game of Life generation. The grid is swept row by row through
//   a request/acknowledge handshake with the row-update datapath. After the
//   last row is acknowledged, a one-cycle commit pulse swaps the current and
//   next grid buffers.
//
//   A generation is started in one of two ways:
//     - by a tick from the update-interval timer while in free-run mode, or
//     - by a single-step pulse while free-run mode is off.
//   A load pulse makes the grid memory latch a new pattern and clears the
//   generation counter. Requests that arrive while the sequencer is busy are
//   dropped.
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous, active-high reset
//   i_run        level: free-run mode, one generation per i_tick
//   i_step       pulse: request one generation (ignored while i_run=1)
//   i_tick       pulse: update-interval tick
//   i_load       pulse: load a pattern and clear the generation count
//   i_row_ack    datapath finished the row at o_row_addr (only while o_row_req)
//   o_row_req    request to compute the row at o_row_addr
//   o_row_addr   row currently requested
//   o_commit     pulse: swap the current/next grid buffers
//   o_load_en    pulse: grid memory latches the input pattern
//   o_busy       high whenever the sequencer is not idle
//   o_gen_count  completed generations since the last reset or load
// -----------------------------------------------------------------------------
module gol_gen_sequencer #(
    parameter int ROWS  = 16,
    parameter int ROW_W = 4,
    parameter int GEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_tick,
    input  logic             i_load,
    input  logic             i_row_ack,
    output logic             o_row_req,
    output logic [ROW_W-1:0] o_row_addr,
    output logic             o_commit,
    output logic             o_load_en,
    output logic             o_busy,
    output logic [GEN_W-1:0] o_gen_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_COMMIT = 2'd2,
        ST_LOAD   = 2'd3
    } state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    state_t             r_state;
    logic               r_row_req;
    logic [ROW_W-1:0]   r_row_addr;
    logic               r_commit;
    logic               r_load_en;
    logic               r_busy;
    logic [GEN_W-1:0]   r_gen_count;

    // A generation trigger: a tick in free-run mode, or a step when not running.
    // A step while running is ignored, so tick+step with run=1 starts one sweep.
    logic w_trigger;
    assign w_trigger = (i_run & i_tick) | (i_step & ~i_run);

    // Sequencer FSM; every output is a register updated alongside the state.
    // The counter changes at the same edge as the pulse that announces it, so
    // the displayed count and the commit/load pulse are always consistent.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_row_req   <= 1'b0;
            r_row_addr  <= '0;
            r_commit    <= 1'b0;
            r_load_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_gen_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_commit  <= 1'b0;
                    r_load_en <= 1'b0;
                    r_row_req <= 1'b0;
                    if (i_load) begin
                        // Load has priority and swallows any coincident trigger.
                        r_state     <= ST_LOAD;
                        r_load_en   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_row_addr  <= '0;
                        r_gen_count <= '0;
                    end else if (w_trigger) begin
                        r_state    <= ST_REQ;
                        r_row_req  <= 1'b1;
                        r_row_addr <= '0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ST_REQ: begin
                    // No timeout: the request is held until the datapath acks.
                    if (i_row_ack) begin
                        if (r_row_addr == LAST_ROW) begin
                            r_state     <= ST_COMMIT;
                            r_row_req   <= 1'b0;
                            r_row_addr  <= '0;
                            r_commit    <= 1'b1;
                            r_gen_count <= r_gen_count + GEN_W'(1);
                        end else begin
                            r_row_addr <= r_row_addr + ROW_W'(1);
                        end
                    end else begin
                        r_row_addr <= r_row_addr;
                    end
                end

                ST_COMMIT: begin
                    r_state  <= ST_IDLE;
                    r_commit <= 1'b0;
                    r_busy   <= 1'b0;
                end

                ST_LOAD: begin
                    r_state   <= ST_IDLE;
                    r_load_en <= 1'b0;
                    r_busy    <= 1'b0;
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_row_req  <= 1'b0;
                    r_row_addr <= '0;
                    r_commit   <= 1'b0;
                    r_load_en  <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign o_row_req   = r_row_req;
    assign o_row_addr  = r_row_addr;
    assign o_commit    = r_commit;
    assign o_load_en   = r_load_en;
    assign o_busy      = r_busy;
    assign o_gen_count = r_gen_count;

endmodule
